decode_imm_ctrl: RTL

Decode-stage controller that sequences the immediate generator. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into an immediate type plus decode flags. Results are held in a one-entry pipeline register backed by a one-entry skid buffer, then presented to the execute stage. The registered `out_imm_type` drives the immediate generator's `imm_type` select, and `out_inst` drives its `inst` input.

---
 rtl/decode_imm_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: classifies opcodes into immediate types and holds
// results in a two-entry main/skid buffer so in_ready comes straight from a flop.
module decode_imm_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imm_type,
  output logic            out_imm_en,
  output logic            out_illegal
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      imm_type;
    logic            imm_en;
    logic            illegal;
  } entry_t;

  entry_t in_ent;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  always_comb begin
    in_ent          = '0;
    in_ent.inst     = in_inst;
    in_ent.pc       = in_pc;
    in_ent.imm_en   = 1'b1;
    unique case (in_inst[6:0])
      7'b0110111, 7'b0010111:                         in_ent.imm_type = IMM_U;
      7'b1101111:                                     in_ent.imm_type = IMM_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: in_ent.imm_type = IMM_I;
      7'b0100011:                                     in_ent.imm_type = IMM_S;
      7'b1100011:                                     in_ent.imm_type = IMM_B;
      7'b0110011: begin
        in_ent.imm_type = IMM_I;
        in_ent.imm_en   = 1'b0;
      end
      default: begin
        in_ent.imm_type = IMM_I;
        in_ent.imm_en   = 1'b0;
        in_ent.illegal  = 1'b1;
      end
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q && drain) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if ((!main_vld_q || drain) && accept) begin
      main_d     = in_ent;
      main_vld_d = 1'b1;
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end else if (drain) begin
      main_vld_d = 1'b0;
    end
    // Ready for next cycle depends only on whether skid will be occupied.
    in_ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_vld_q;
  assign out_inst     = main_q.inst;
  assign out_pc       = main_q.pc;
  assign out_imm_type = main_q.imm_type;
  assign out_imm_en   = main_q.imm_en;
  assign out_illegal  = main_q.illegal;

endmodule
